// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int          DEF_MAX_STREAK     = 4;
    localparam int          DEF_TIMEOUT_CYCLES = 64;
    localparam logic [31:0] DEF_ERR_DATA       = 32'h0000_0000;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Two-way fetch/data picker: data wins unless fetch has waited through
// MAX_STREAK back-to-back data grants.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_STREAK = DEF_MAX_STREAK
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   take,
    input  logic   if_req,
    input  logic   d_req,
    output logic   gnt_en,
    output owner_t winner
);

    localparam int SW = $clog2(MAX_STREAK + 1);

    logic [SW-1:0] streak;
    logic          starved;

    always_comb begin
        starved = if_req && d_req && (streak == SW'(MAX_STREAK));
        gnt_en  = take && (if_req || d_req);
        winner  = (d_req && !starved) ? OWN_D : OWN_IF;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak <= '0;
        end else if (gnt_en) begin
            if (winner == OWN_D && if_req) begin
                if (streak != SW'(MAX_STREAK))
                    streak <= streak + 1'b1;
            end else begin
                streak <= '0;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store; one access in flight,
// sequenced IDLE -> ISSUE -> (WAIT) -> IDLE with a per-access timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int          MAX_STREAK     = DEF_MAX_STREAK,
    parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter logic [31:0] ERR_DATA       = DEF_ERR_DATA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wmask,
    input  logic [3:0]  d_rmask,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_mask,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        timeout_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    state_t        state, state_next;
    owner_t        owner, winner;
    logic          gnt_en;
    logic          lat_we;
    logic [31:0]   lat_addr, lat_wdata;
    logic [3:0]    lat_mask;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_last, resp_fire, tmo_fire;
    logic [31:0]   resp_data;

    mem_arb_pick #(.MAX_STREAK(MAX_STREAK)) u_pick (
        .clk    (clk),
        .rst    (rst),
        .take   (state == ST_IDLE),
        .if_req (if_req),
        .d_req  (d_req),
        .gnt_en (gnt_en),
        .winner (winner)
    );

    assign tmo_last = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // A completing write beats the timeout; a read accepted on the last cycle does not.
    always_comb begin
        state_next = state;
        resp_fire  = 1'b0;
        resp_data  = '0;
        tmo_fire   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (gnt_en) state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (mem_ready && lat_we) begin
                    resp_fire  = 1'b1;
                    state_next = ST_IDLE;
                end else if (tmo_last) begin
                    tmo_fire   = 1'b1;
                    resp_fire  = 1'b1;
                    resp_data  = ERR_DATA;
                    state_next = ST_IDLE;
                end else if (mem_ready) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    resp_fire  = 1'b1;
                    resp_data  = mem_rdata;
                    state_next = ST_IDLE;
                end else if (tmo_last) begin
                    tmo_fire   = 1'b1;
                    resp_fire  = 1'b1;
                    resp_data  = ERR_DATA;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner       <= OWN_IF;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_mask    <= '0;
            tmo_cnt     <= '0;
            if_gnt      <= 1'b0;
            d_gnt       <= 1'b0;
            if_rvalid   <= 1'b0;
            d_rvalid    <= 1'b0;
            if_rdata    <= '0;
            d_rdata     <= '0;
            timeout_err <= 1'b0;
        end else begin
            if_gnt    <= gnt_en && (winner == OWN_IF);
            d_gnt     <= gnt_en && (winner == OWN_D);
            if_rvalid <= resp_fire && (owner == OWN_IF);
            d_rvalid  <= resp_fire && (owner == OWN_D);
            tmo_cnt   <= (state == ST_IDLE) ? '0 : tmo_cnt + 1'b1;

            if (gnt_en) begin
                owner <= winner;
                if (winner == OWN_D) begin
                    lat_we    <= d_we;
                    lat_addr  <= d_addr;
                    lat_wdata <= d_wdata;
                    lat_mask  <= d_we ? d_wmask : d_rmask;
                end else begin
                    lat_we    <= 1'b0;
                    lat_addr  <= if_addr;
                    lat_wdata <= '0;
                    lat_mask  <= 4'hF;
                end
            end

            if (resp_fire) begin
                if (owner == OWN_IF) if_rdata <= resp_data;
                else                 d_rdata  <= resp_data;
            end

            if (tmo_fire) timeout_err <= 1'b1;
        end
    end

    assign busy      = (state != ST_IDLE);
    assign mem_req   = (state == ST_ISSUE);
    assign mem_we    = mem_req && lat_we;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign mem_mask  = lat_mask;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data/instruction memory port between the fetch unit (read-only) and the execute-stage load/store path (memAddr/memData/readWr/writeWr/rmask/wmask).
- Sequences each access as issue → accept → response and routes read data back to the owner.
- Data has priority over fetch, with an anti-starvation limit.
- Sits between IFU/EXU and the memory model; one access is outstanding at a time.

Parameters:
- MAX_STREAK, 4: consecutive data grants allowed while fetch waits; then fetch wins one grant.
- TIMEOUT_CYCLES, 64: cycles in ISSUE+WAIT before the access is aborted.
- ERR_DATA, 32'h0000_0000: rdata returned on timeout.

Ports:
- clk in 1: clock, rising edge.
- rst in 1: reset, synchronous, active-high.
- if_req in 1: fetch request.
- if_addr in 32: fetch address.
- if_gnt out 1: fetch request latched (1-cycle pulse).
- if_rvalid out 1: fetch data valid (1-cycle pulse).
- if_rdata out 32: fetch read data.
- d_req in 1: data request (readWr|writeWr).
- d_we in 1: 1 = store, 0 = load.
- d_addr in 32: data address.
- d_wdata in 32: store data.
- d_wmask in 4: store byte mask.
- d_rmask in 4: load byte mask.
- d_gnt out 1: data request latched (1-cycle pulse).
- d_rvalid out 1: load data valid, or store done (1-cycle pulse).
- d_rdata out 32: load data (0 for stores).
- mem_req out 1: memory request.
- mem_we out 1: memory write enable.
- mem_addr out 32: memory address.
- mem_wdata out 32: memory write data.
- mem_mask out 4: wmask on writes, rmask on reads.
- mem_ready in 1: memory accepts the request this cycle.
- mem_rvalid in 1: read data valid.
- mem_rdata in 32: read data.
- busy out 1: FSM not in IDLE.
- timeout_err out 1: sticky; set when an access times out.

Behaviour:
- Reset:
  - All outputs 0; FSM = IDLE; streak = 0; timeout counter = 0; timeout_err = 0.
  - Reset mid-access abandons the access: mem_req = 0 the next cycle, and no rvalid is generated.
- Requester rule: hold req and fields stable until gnt is seen; then drop req or present the next request.
- IDLE (reqs sampled only in IDLE):
  - If any req, pick a winner, latch its fields and owner, pulse the owner's gnt next cycle, and go to ISSUE.
  - Winner: data, unless if_req && d_req && streak == MAX_STREAK, in which case fetch wins.
  - streak: +1 on a data grant while if_req = 1 (saturates at MAX_STREAK). Cleared on a fetch grant or on any grant with if_req = 0.
- ISSUE:
  - mem_req = 1 with latched fields, held until mem_ready.
  - On mem_ready: write → d_rvalid pulse next cycle, d_rdata = 0, go to IDLE. Read → go to WAIT.
- WAIT:
  - mem_req = 0.
  - On mem_rvalid: register mem_rdata to the owner's rdata and pulse the owner's rvalid next cycle; go to IDLE.
- Response routing and hold:
  - The non-owner's rvalid stays 0.
  - rdata holds its value until the next response to the same owner.
- Timing:
  - A new request may be latched in the same cycle its predecessor's rvalid is output.
  - Zero-wait memory (mem_ready with mem_req, mem_rvalid next cycle): read req at cycle 0 → gnt/mem_req at cycle 1 → rvalid out at cycle 3.
  - Sustained throughput: 1 read per 3 cycles.
- Timeout:
  - Counter runs in ISSUE/WAIT and clears on entry to IDLE.
  - At TIMEOUT_CYCLES: set timeout_err, pulse the owner's rvalid with ERR_DATA, drop mem_req, go to IDLE.
- mem_rvalid received in IDLE or ISSUE is ignored (stale or late response).
- mem_ready while mem_req = 0 is ignored.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE/ISSUE/WAIT).
  - Owner IDs (OWN_IF, OWN_D).
  - Defaults for MAX_STREAK, TIMEOUT_CYCLES, ERR_DATA.
- One sub-module, mem_arb_pick: 2-way priority picker plus the streak counter. Outputs the winner and grant-enable; the parent owns the FSM, latches and timeout.

Test Plan:
- Zero-wait memory, d_req load addr 0x100, rdata 0x1234_5678 → d_gnt at cycle 1, d_rvalid at cycle 3 with d_rdata 0x1234_5678; if_rvalid stays 0.
- if_req and d_req held continuously, MAX_STREAK = 4 → grant order D,D,D,D,IF,D,D,D,D,IF.
- Store addr 0x200, wdata 0xCAFE_F00D, wmask 4'b0011, mem_ready delayed 3 cycles → mem_req held 4 cycles with stable fields, mem_mask = 0011, d_rvalid pulse with d_rdata = 0.
- Read with mem_rvalid never asserted, TIMEOUT_CYCLES = 8 → owner rvalid with ERR_DATA, timeout_err = 1 and stays set; a late mem_rvalid in IDLE produces no rvalid.
- rst asserted during WAIT, then mem_rvalid → no rvalid, all outputs 0; a fetch issued after reset completes normally.
